// File: rtl/dbg_cmd_bridge.sv
// Debug command bridge: buffers host commands in a FIFO, replays them on the debug register bus
// and returns one response per command. Optional ack timeout via `define DBG_TIMEOUT_EN.
module dbg_cmd_bridge #(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_write_data,
  input  logic [DATA_WIDTH-1:0] dbg_read_data,
  output logic                  dbg_wr_en,
  output logic                  dbg_req,
  input  logic                  dbg_ack,
  output logic                  term_req,
  output logic                  trace_start
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] TERM_DATA  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] TRACE_DATA = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dbg_cmd_bridge: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, READ, ISSUE, RESP} state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              ready_en;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic              head_rnw;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic              head_wr0;
  logic              hold_rnw;

  // ready_en keeps cmd_ready low for the first cycle after reset
  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign cmd_ready = ready_en && !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty && !dbg_ack;

  assign head      = mem[rd_ptr[IDX_W-1:0]];
  assign head_rnw  = head[ENT_W-1];
  assign head_addr = head[ENT_W-2 -: ADDR_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];
  assign head_wr0  = !head_rnw && (head_addr == '0);

  assign dbg_req   = (state == ISSUE) && !dbg_ack && !rst;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= {cmd_rnw, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

`ifdef DBG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Command sequencer; pulses (wr_en, term_req, trace_start) default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold_rnw       <= 1'b0;
      dbg_addr       <= '0;
      dbg_write_data <= '0;
      dbg_wr_en      <= 1'b0;
      term_req       <= 1'b0;
      trace_start    <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
`ifdef DBG_TIMEOUT_EN
      rsp_err        <= 1'b0;
      cnt            <= '0;
`endif
    end else begin
      dbg_wr_en   <= 1'b0;
      term_req    <= 1'b0;
      trace_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            hold_rnw       <= head_rnw;
            dbg_addr       <= head_addr;
            dbg_write_data <= head_data;
            if (head_wr0 && head_data == TERM_DATA) begin
              term_req  <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              trace_start <= head_wr0 && (head_data == TRACE_DATA);
              dbg_wr_en   <= !head_rnw;
              state       <= SETUP;
            end
          end
        end
        SETUP: begin
          if (hold_rnw) begin
            state <= READ;
          end else if (dbg_addr == '0) begin
            state <= ISSUE;
`ifdef DBG_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        READ: begin
          rsp_data  <= dbg_read_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        ISSUE: begin
          if (dbg_ack) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef DBG_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef DBG_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Directed self-checking bench for dbg_cmd_bridge (timeout steps need DBG_TIMEOUT_EN).
module tb_dbg_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  dbg_addr;
  logic [31:0] dbg_write_data;
  logic [31:0] dbg_read_data;
  logic        dbg_wr_en;
  logic        dbg_req;
  logic        dbg_ack;
  logic        term_req;
  logic        trace_start;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_table [4];
  assign dbg_read_data = rd_table[dbg_addr];

  always #5 clk = ~clk;

  dbg_cmd_bridge #(
    .ADDR_WIDTH(2), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dbg_addr(dbg_addr), .dbg_write_data(dbg_write_data), .dbg_read_data(dbg_read_data),
    .dbg_wr_en(dbg_wr_en), .dbg_req(dbg_req), .dbg_ack(dbg_ack),
    .term_req(term_req), .trace_start(trace_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command and hold it until accepted; returns in the cycle after the push edge
  task automatic push(input logic rnw, input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_rnw = rnw; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic        b_rnw  [6];
  logic [1:0]  b_addr [6];
  logic [31:0] b_data [6];
  logic [31:0] b_exp  [6];

  initial begin
    int idx;
    int n;
    int cnt;
    logic acc;

    rd_table[0] = 32'h0000_0000;
    rd_table[1] = 32'h1111_0001;
    rd_table[2] = 32'hDEAD_BEEF;
    rd_table[3] = 32'h3333_0003;
    b_rnw[0] = 1'b1; b_addr[0] = 2'd1; b_data[0] = 32'h0;  b_exp[0] = 32'h1111_0001;
    b_rnw[1] = 1'b0; b_addr[1] = 2'd1; b_data[1] = 32'h11; b_exp[1] = 32'h0;
    b_rnw[2] = 1'b1; b_addr[2] = 2'd3; b_data[2] = 32'h0;  b_exp[2] = 32'h3333_0003;
    b_rnw[3] = 1'b0; b_addr[3] = 2'd3; b_data[3] = 32'h33; b_exp[3] = 32'h0;
    b_rnw[4] = 1'b1; b_addr[4] = 2'd2; b_data[4] = 32'h0;  b_exp[4] = 32'hDEAD_BEEF;
    b_rnw[5] = 1'b1; b_addr[5] = 2'd3; b_data[5] = 32'h0;  b_exp[5] = 32'h3333_0003;

    rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1; dbg_ack = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_dbg_req", 32'(dbg_req), 32'd0);
    chk("rst_wr_en", 32'(dbg_wr_en), 32'd0);
    chk("rst_dbg_addr", 32'(dbg_addr), 32'd0);
    chk("rst_term", 32'(term_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("post_rst_ready_high", 32'(cmd_ready), 32'd1);

    // Step 1: read addr 2
    push(1'b1, 2'd2, 32'h0);
    tick();
    chk("rd_setup_wr_en", 32'(dbg_wr_en), 32'd0);
    chk("rd_setup_addr", 32'(dbg_addr), 32'd2);
    chk("rd_setup_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd_read_valid", 32'(rsp_valid), 32'd0);
    chk("rd_read_wr_en", 32'(dbg_wr_en), 32'd0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    chk("rd_rsp_done", 32'(rsp_valid), 32'd0);
    chk("rd_rsp_cleared", rsp_data, 32'd0);

    // Step 2: write addr 0, ack five cycles after req rises
    push(1'b0, 2'd0, 32'h12);
    tick();
    chk("w0_setup_wr_en", 32'(dbg_wr_en), 32'd1);
    chk("w0_setup_req", 32'(dbg_req), 32'd0);
    chk("w0_wdata", dbg_write_data, 32'h12);
    tick();
    chk("w0_issue_wr_en", 32'(dbg_wr_en), 32'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (dbg_req) cnt++;
      tick();
    end
    chk("w0_req_cycles", 32'(cnt), 32'd5);
    dbg_ack = 1'b1;
    #1;
    chk("w0_req_falls_on_ack", 32'(dbg_req), 32'd0);
    tick();
    dbg_ack = 1'b0;
    chk("w0_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("w0_rsp_data", rsp_data, 32'd0);
    tick(); tick();

    // Step 3: six-command burst against a four-entry FIFO with responses stalled
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = (idx < 6);
      if (idx < 6) begin
        cmd_rnw = b_rnw[idx]; cmd_addr = b_addr[idx]; cmd_data = b_data[idx];
      end
      #1;
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) idx++;
    end
    chk("burst_accepted", 32'(idx), 32'd5);
    chk("burst_ready_low", 32'(cmd_ready), 32'd0);
    chk("burst_first_rsp_held", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      cmd_valid = (idx < 6);
      if (idx < 6) begin
        cmd_rnw = b_rnw[idx]; cmd_addr = b_addr[idx]; cmd_data = b_data[idx];
      end
      #1;
      acc = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        chk($sformatf("burst_rsp%0d", n), rsp_data, b_exp[n]);
        n++;
      end
      tick();
      if (acc) idx++;
    end
    cmd_valid = 1'b0;
    chk("burst_rsp_count", 32'(n), 32'd6);
    chk("burst_all_pushed", 32'(idx), 32'd6);
    tick(); tick();

    // Step 4: terminate and trace-start specials
    push(1'b0, 2'd0, 32'hFFFF_FFFF);
    tick();
    chk("term_pulse", 32'(term_req), 32'd1);
    chk("term_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("term_rsp_data", rsp_data, 32'd0);
    chk("term_wr_en", 32'(dbg_wr_en), 32'd0);
    chk("term_req_bus", 32'(dbg_req), 32'd0);
    tick();
    chk("term_pulse_end", 32'(term_req), 32'd0);
    chk("term_one_rsp", 32'(rsp_valid), 32'd0);
    chk("term_no_req", 32'(dbg_req), 32'd0);
    push(1'b0, 2'd0, 32'hFFFF_FFFE);
    tick();
    chk("trace_pulse", 32'(trace_start), 32'd1);
    chk("trace_wr_en", 32'(dbg_wr_en), 32'd1);
    tick();
    chk("trace_pulse_end", 32'(trace_start), 32'd0);
    chk("trace_issue_req", 32'(dbg_req), 32'd1);
    dbg_ack = 1'b1;
    #1;
    chk("trace_req_ack", 32'(dbg_req), 32'd0);
    tick();
    dbg_ack = 1'b0;
    chk("trace_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();

    // Step 5: reset during ISSUE with a second command queued
    push(1'b0, 2'd0, 32'h55);
    push(1'b1, 2'd2, 32'h0);
    tick();
    chk("rst5_in_issue", 32'(dbg_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst5_req", 32'(dbg_req), 32'd0);
    chk("rst5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst5_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst5_ready_first", 32'(cmd_ready), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || dbg_wr_en || dbg_addr != 2'd0) cnt++;
    end
    chk("rst5_fifo_flushed", 32'(cnt), 32'd0);

    // Read after reset, with a stray ack holding off the pop
    dbg_ack = 1'b1;
    push(1'b1, 2'd2, 32'h0);
    repeat (4) tick();
    chk("ack_blocks_pop", 32'(rsp_valid), 32'd0);
    chk("ack_blocks_addr", 32'(dbg_addr), 32'd0);
    dbg_ack = 1'b0;
    tick(); tick();
    chk("post_rst_rd_early", 32'(rsp_valid), 32'd0);
    tick();
    chk("post_rst_rd_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_rd_data", rsp_data, 32'hDEAD_BEEF);
    tick();

`ifdef DBG_TIMEOUT_EN
    // Step 6: ack timeout, then ack landing on the last allowed cycle
    push(1'b0, 2'd0, 32'h66);
    tick(); tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (dbg_req) cnt++;
      tick();
    end
    chk("to_req_cycles", 32'(cnt), 32'd8);
    chk("to_req_low", 32'(dbg_req), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    tick();
    chk("to_err_cleared", 32'(rsp_err), 32'd0);
    push(1'b0, 2'd0, 32'h67);
    tick(); tick();
    repeat (7) tick();
    chk("to2_req_cycle8", 32'(dbg_req), 32'd1);
    dbg_ack = 1'b1;
    #1;
    tick();
    dbg_ack = 1'b0;
    chk("to2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to2_rsp_err", 32'(rsp_err), 32'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
